pulse_dispatch: RTL and testbench

PULSE_DISPATCH -- requirements
Module: pulse_dispatch

---
 rtl/pulse_dispatch_pkg.sv | 19 +
 rtl/cmd_fifo.sv | 63 ++++++
 rtl/pulse_dispatch.sv | 108 ++++++++++
 tb/tb_pulse_dispatch.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_dispatch_pkg.sv
// Shared widths and the queued-command record for the pulse dispatcher.
// Field "ts" carries the fire time ("time" is a reserved word).
package pulse_dispatch_pkg;

    localparam int PULSE_OUT_WIDTH = 72;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_CHAN_W      = 2;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]  ts;
        logic [DEF_CHAN_W-1:0]      chan;
        logic [PULSE_OUT_WIDTH-1:0] cmd;
    } entry_t;

    function automatic int entry_width(input int data_w, input int chan_w, input int cmd_w);
        return data_w + chan_w + cmd_w;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular command queue: power-of-2 depth, show-ahead head, synchronous flush.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pulse_dispatch.sv
// Time-triggered pulse dispatcher: fires queued commands on a free-running
// quantum clock, dropping (and flagging) entries whose time already passed.
module pulse_dispatch #(
    parameter int DATA_WIDTH      = 32,
    parameter int PULSE_OUT_WIDTH = pulse_dispatch_pkg::PULSE_OUT_WIDTH,
    parameter int N_CHAN          = 4,
    parameter int DEPTH           = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_time,
    input  logic [$clog2(N_CHAN)-1:0]         in_chan,
    input  logic [PULSE_OUT_WIDTH-1:0]        in_cmd,
    input  logic                              qclk_load_en,
    input  logic [DATA_WIDTH-1:0]             qclk_load_val,
    input  logic                              flush,
    input  logic                              err_clear,
    output logic [DATA_WIDTH-1:0]             qclk_out,
    output logic [N_CHAN*PULSE_OUT_WIDTH-1:0] cmd_out,
    output logic [N_CHAN-1:0]                 cstrobe_out,
    output logic                              late_err,
    output logic [$clog2(DEPTH):0]            count
);

    import pulse_dispatch_pkg::*;

    localparam int CHAN_W  = $clog2(N_CHAN);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = entry_width(DATA_WIDTH, CHAN_W, PULSE_OUT_WIDTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]      ts;
        logic [CHAN_W-1:0]          chan;
        logic [PULSE_OUT_WIDTH-1:0] cmd;
    } dispatch_entry_t;

    dispatch_entry_t            in_entry, head;
    logic [DATA_WIDTH-1:0]      qclk_q, qclk_d, slack;
    logic [N_CHAN-1:0]          strobe_q, strobe_d;
    logic [PULSE_OUT_WIDTH-1:0] cmd_q [N_CHAN];
    logic                       late_q, late_d;
    logic                       non_empty, fire, drop, push, pop;

    assign in_entry = '{ts: in_time, chan: in_chan, cmd: in_cmd};

    cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (in_entry),
        .head    (head),
        .count   (count)
    );

    assign in_ready  = (count != FULL_CNT);
    assign push      = in_valid & in_ready;
    assign non_empty = (count != '0);
    // Wrapping difference: a negative slack means the head's time has passed.
    assign slack     = head.ts - qclk_q;
    assign fire      = non_empty && (slack == '0) && !flush;
    assign drop      = non_empty && slack[DATA_WIDTH-1] && !flush;
    assign pop       = fire | drop;

    always_comb begin
        qclk_d   = qclk_load_en ? qclk_load_val : qclk_q + DATA_WIDTH'(1);
        late_d   = drop | (late_q & ~err_clear);
        strobe_d = '0;
        for (int unsigned c = 0; c < N_CHAN; c++) begin
            strobe_d[c] = fire && (head.chan == CHAN_W'(c));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qclk_q   <= '0;
            strobe_q <= '0;
            late_q   <= 1'b0;
            for (int unsigned c = 0; c < N_CHAN; c++) cmd_q[c] <= '0;
        end else begin
            qclk_q   <= qclk_d;
            strobe_q <= strobe_d;
            late_q   <= late_d;
            for (int unsigned c = 0; c < N_CHAN; c++) begin
                if (strobe_d[c]) cmd_q[c] <= head.cmd;
            end
        end
    end

    always_comb begin
        cmd_out = '0;
        for (int unsigned c = 0; c < N_CHAN; c++) begin
            cmd_out[c*PULSE_OUT_WIDTH +: PULSE_OUT_WIDTH] = cmd_q[c];
        end
    end

    assign qclk_out    = qclk_q;
    assign cstrobe_out = strobe_q;
    assign late_err    = late_q;

endmodule

// File: tb/tb_pulse_dispatch.sv
// Self-checking bench for pulse_dispatch with a queue-based reference model.
module tb_pulse_dispatch;

    localparam int DW = 32;
    localparam int PW = 72;
    localparam int NC = 4;
    localparam int DP = 8;

    typedef struct {
        logic [DW-1:0] t;
        logic [1:0]    ch;
        logic [PW-1:0] cmd;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset, in_valid, in_ready, qclk_load_en, flush, err_clear, late_err;
    logic [DW-1:0]    in_time, qclk_load_val, qclk_out;
    logic [1:0]       in_chan;
    logic [PW-1:0]    in_cmd;
    logic [NC*PW-1:0] cmd_out;
    logic [NC-1:0]    cstrobe_out;
    logic [3:0]       count;

    int vectors = 0;
    int miscompares = 0;

    ent_t             mq[$];
    logic [DW-1:0]    m_qclk;
    logic [NC-1:0]    m_strobe;
    logic             m_late;
    logic [NC*PW-1:0] m_cmd;

    always #5 clk = ~clk;

    pulse_dispatch #(
        .DATA_WIDTH      (DW),
        .PULSE_OUT_WIDTH (PW),
        .N_CHAN          (NC),
        .DEPTH           (DP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_time       (in_time),
        .in_chan       (in_chan),
        .in_cmd        (in_cmd),
        .qclk_load_en  (qclk_load_en),
        .qclk_load_val (qclk_load_val),
        .flush         (flush),
        .err_clear     (err_clear),
        .qclk_out      (qclk_out),
        .cmd_out       (cmd_out),
        .cstrobe_out   (cstrobe_out),
        .late_err      (late_err),
        .count         (count)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of the reference behaviour, from the inputs currently driven.
    task automatic model_step();
        logic [DW-1:0] slack;
        bit            ready, late_set;
        ent_t          e;
        ready    = (mq.size() < DP);
        late_set = 1'b0;
        m_strobe = '0;
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) begin
                slack = mq[0].t - m_qclk;
                if (slack == 0) begin
                    m_strobe[mq[0].ch] = 1'b1;
                    m_cmd[int'(mq[0].ch)*PW +: PW] = mq[0].cmd;
                    void'(mq.pop_front());
                end else if (slack[DW-1]) begin
                    late_set = 1'b1;
                    void'(mq.pop_front());
                end
            end
            if (in_valid && ready) begin
                e.t = in_time; e.ch = in_chan; e.cmd = in_cmd;
                mq.push_back(e);
            end
        end
        m_late = late_set ? 1'b1 : (err_clear ? 1'b0 : m_late);
        m_qclk = qclk_load_en ? qclk_load_val : m_qclk + 1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_time = '0; in_chan = '0; in_cmd = '0;
        qclk_load_en = 0; qclk_load_val = '0; flush = 0; err_clear = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_qclk = '0; m_strobe = '0; m_late = 0; m_cmd = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (qclk_out !== 32'd0) begin miscompares++; $display("FAIL reset_qclk got=%h exp=0", qclk_out); end
        vectors++;
        if (count !== 4'd0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_queue count=%0d ready=%b exp count=0 ready=1", count, in_ready);
        end
        vectors++;
        if (cstrobe_out !== 4'd0 || late_err !== 1'b0 || cmd_out !== '0) begin
            miscompares++; $display("FAIL reset_outs strobe=%b late=%b cmd_nonzero=%b exp 0", cstrobe_out, late_err, |cmd_out);
        end
    endtask

    task automatic test_single_fire();
        bit seen = 0;
        apply_reset();
        for (int i = 0; i < 10 && qclk_out != 32'd5; i++) tick();
        in_valid = 1; in_time = 32'd20; in_chan = 2'd2; in_cmd = 72'hA5;
        tick();
        in_valid = 0;
        vectors++;
        if (count !== 4'd1) begin miscompares++; $display("FAIL single_push count=%0d exp=1", count); end
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (cstrobe_out != 0) begin
                seen = 1;
                vectors++;
                if (cstrobe_out !== 4'b0100 || qclk_out !== 32'd21) begin
                    miscompares++; $display("FAIL single_strobe strobe=%b qclk=%0d exp strobe=0100 qclk=21", cstrobe_out, qclk_out);
                end
            end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL single_timeout no strobe seen exp one strobe"); end
        tick();
        vectors++;
        if (cstrobe_out !== 4'd0 || cmd_out[2*PW +: PW] !== 72'hA5) begin
            miscompares++; $display("FAIL single_hold strobe=%b cmd2=%h exp strobe=0 cmd2=a5", cstrobe_out, cmd_out[2*PW +: PW]);
        end
    endtask

    task automatic test_same_time();
        int          nstrobe = 0;
        logic [3:0]  first_strobe = '0;
        logic [31:0] strobe_qclk = '0;
        logic [31:0] times [3] = '{32'd30, 32'd30, 32'd31};
        logic [1:0]  chans [3] = '{2'd0, 2'd1, 2'd3};
        apply_reset();
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_time = times[i]; in_chan = chans[i]; in_cmd = 72'h100 + 72'(i);
            tick();
        end
        in_valid = 0;
        for (int i = 0; i < 40 && qclk_out != 32'd34; i++) begin
            tick();
            vectors++;
            if (count !== 4'(mq.size())) begin
                miscompares++; $display("FAIL same_count qclk=%0d count=%0d exp=%0d", qclk_out, count, mq.size());
            end
            if (cstrobe_out != 0) begin
                nstrobe++;
                if (nstrobe == 1) begin first_strobe = cstrobe_out; strobe_qclk = qclk_out; end
            end
        end
        vectors++;
        if (nstrobe != 1 || first_strobe !== 4'b0001 || strobe_qclk !== 32'd31) begin
            miscompares++; $display("FAIL same_strobe n=%0d strobe=%b qclk=%0d exp n=1 strobe=0001 qclk=31", nstrobe, first_strobe, strobe_qclk);
        end
        vectors++;
        if (late_err !== 1'b1 || count !== 4'd0) begin
            miscompares++; $display("FAIL same_late late=%b count=%0d exp late=1 count=0", late_err, count);
        end
    endtask

    task automatic test_full();
        logic [1:0] first_ch = '0;
        bit seen = 0;
        apply_reset();
        qclk_load_en = 1; qclk_load_val = 32'd990;
        tick();
        qclk_load_en = 0;
        for (int i = 0; i < DP; i++) begin
            in_valid = 1; in_time = 32'd1000; in_chan = 2'($urandom_range(0, 3));
            in_cmd = {8'(i), $urandom, $urandom};
            if (i == 0) first_ch = in_chan;
            tick();
        end
        vectors++;
        if (in_ready !== 1'b0 || count !== 4'd8) begin
            miscompares++; $display("FAIL full_state ready=%b count=%0d exp ready=0 count=8", in_ready, count);
        end
        in_valid = 1; in_time = 32'd1005; in_chan = 2'd3; in_cmd = 72'hDEAD;
        tick();
        vectors++;
        if (count !== 4'd8) begin miscompares++; $display("FAIL full_refuse count=%0d exp=8", count); end
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (cstrobe_out != 0) begin
                seen = 1;
                vectors++;
                if (count !== 4'd7 || in_ready !== 1'b1 || cstrobe_out !== (4'b0001 << first_ch)) begin
                    miscompares++; $display("FAIL full_fire count=%0d ready=%b strobe=%b exp count=7 ready=1 strobe=%b", count, in_ready, cstrobe_out, 4'b0001 << first_ch);
                end
            end
            in_valid = 0;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL full_timeout no strobe seen exp one strobe"); end
    endtask

    task automatic test_wrap();
        logic [1:0]  ch;
        logic [71:0] c;
        bit seen = 0;
        apply_reset();
        qclk_load_en = 1; qclk_load_val = 32'hFFFF_FFFE;
        tick();
        qclk_load_en = 0;
        ch = 2'($urandom_range(0, 3)); c = {$urandom, $urandom, $urandom};
        in_valid = 1; in_time = 32'h0000_0001; in_chan = ch; in_cmd = c;
        tick();
        in_valid = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (cstrobe_out != 0) begin
                seen = 1;
                vectors++;
                if (qclk_out !== 32'd2 || cstrobe_out !== (4'b0001 << ch) || late_err !== 1'b0) begin
                    miscompares++; $display("FAIL wrap_fire qclk=%h strobe=%b late=%b exp qclk=2 strobe=%b late=0", qclk_out, cstrobe_out, late_err, 4'b0001 << ch);
                end
                vectors++;
                if (cmd_out[int'(ch)*PW +: PW] !== c) begin
                    miscompares++; $display("FAIL wrap_cmd got=%h exp=%h", cmd_out[int'(ch)*PW +: PW], c);
                end
            end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL wrap_timeout no strobe seen exp one strobe"); end
    endtask

    task automatic test_flush();
        logic [31:0] t;
        apply_reset();
        repeat (3) tick();
        in_valid = 1; in_time = 32'd0; in_chan = 2'd1; in_cmd = 72'h77;
        tick();
        in_valid = 0;
        tick();
        vectors++;
        if (late_err !== 1'b1 || count !== 4'd0) begin
            miscompares++; $display("FAIL flush_setup late=%b count=%0d exp late=1 count=0", late_err, count);
        end
        t = qclk_out + 5;
        in_valid = 1; in_time = t; in_chan = 2'd2; in_cmd = 72'h55;
        tick();
        in_valid = 0;
        for (int i = 0; i < 10 && qclk_out != t; i++) tick();
        flush = 1; in_valid = 1; in_time = t + 3; in_chan = 2'd0; in_cmd = 72'h66;
        tick();
        flush = 0; in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (count !== 4'd0 || cstrobe_out !== 4'd0 || late_err !== 1'b1 || cmd_out !== m_cmd || qclk_out !== m_qclk) begin
                miscompares++; $display("FAIL flush_after i=%0d count=%0d strobe=%b late=%b qclk=%0d exp count=0 strobe=0 late=1 qclk=%0d", i, count, cstrobe_out, late_err, qclk_out, m_qclk);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_time = qclk_out + 50; in_chan = 2'(i); in_cmd = 72'(i + 1);
            tick();
        end
        in_valid = 0;
        tick();
        vectors++;
        if (count !== 4'd5) begin miscompares++; $display("FAIL rstmid_fill count=%0d exp=5", count); end
        #3;
        reset = 1;
        model_reset();
        #1;
        vectors++;
        if (count !== 4'd0 || in_ready !== 1'b1 || cstrobe_out !== 4'd0) begin
            miscompares++; $display("FAIL rstmid_async count=%0d ready=%b strobe=%b exp 0/1/0", count, in_ready, cstrobe_out);
        end
        @(posedge clk);
        #1;
        reset = 0;
        vectors++;
        if (qclk_out !== 32'd0 || cmd_out !== '0 || late_err !== 1'b0 || count !== 4'd0 || cstrobe_out !== 4'd0) begin
            miscompares++; $display("FAIL rstmid_release qclk=%0d late=%b count=%0d strobe=%b exp all 0", qclk_out, late_err, count, cstrobe_out);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            vectors++;
            if (cstrobe_out !== 4'd0 || count !== 4'd0) begin
                miscompares++; $display("FAIL rstmid_quiet i=%0d strobe=%b count=%0d exp 0/0", i, cstrobe_out, count);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid      = ($urandom_range(0, 1) == 1);
            in_time       = m_qclk + $urandom_range(0, 24) - 4;
            in_chan       = 2'($urandom_range(0, 3));
            in_cmd        = {8'($urandom), $urandom, $urandom};
            qclk_load_en  = ($urandom_range(0, 63) == 0);
            qclk_load_val = $urandom;
            err_clear     = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 49) == 0);
            tick();
            vectors++;
            if (qclk_out !== m_qclk || cstrobe_out !== m_strobe || late_err !== m_late ||
                count !== 4'(mq.size()) || in_ready !== (mq.size() < DP) || cmd_out !== m_cmd) begin
                miscompares++;
                $display("FAIL random cyc=%0d qclk=%h/%h strobe=%b/%b late=%b/%b count=%0d/%0d ready=%b cmd_ok=%b",
                         i, qclk_out, m_qclk, cstrobe_out, m_strobe, late_err, m_late, count, mq.size(), in_ready, cmd_out === m_cmd);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_same_time();
        test_full();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
